pe_column_drain: RTL and testbench
==================================

# pe_column_drain

Result-drain controller for one column of the systolic float multiply-accumulate array. It sits directly downstream of the column's bottom PE. It sequences the column's shift-out chain by driving each PE's `enableShiftOut` and zero-filling the top PE's `cIn`. It captures each accumulator word as it leaves the bottom PE and delivers the words, bottom row first, on a valid/ready stream through a small internal FIFO, with backpressure.

## Interface
- `EXP_OUT`, 5: accumulator exponent width.
- `FRAC_OUT`, 8: accumulator fraction width; word width W = EXP_OUT+FRAC_OUT+1.
- `ROWS`, 4: PEs per column (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to drain the column.
- `mulActive`  in  1  high while the array is in multiply mode (`enableMul` asserted anywhere in the column).
- `cChainIn`  in  W  `cOut` of the bottom PE.
- `cTopOut`  out  W  drives top PE `cIn`; constant 0.
- `enableShiftOut`  out  1  broadcast to every PE in the column.
- `outData`  out  W  drained accumulator word.
- `outValid`  out  1  `outData` valid.
- `outReady`  in  1  consumer accepts the word when `outValid && outReady`.
- `outLast`  out  1  marks the word from the top PE (row 0), the ROWS-th word.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, SHIFT, FLUSH.
  - IDLE → SHIFT on `start && !mulActive`. `start` in any other state or condition is ignored and not latched.
  - SHIFT → FLUSH on the edge that performs the ROWS-th shift.
  - FLUSH → IDLE on the edge where the `outLast` word is popped. `done` is registered and high for the following cycle.
- `enableShiftOut = (state==SHIFT) && !fifoFull`. It is combinational from registered state only. It is never asserted in IDLE or FLUSH.
- Each cycle with `enableShiftOut` high pushes `cChainIn` into the FIFO, together with a last flag set when shiftCount == ROWS-1.
- shiftCount uses `$clog2(ROWS+1)` bits. It clears on IDLE→SHIFT and increments per push.
- A full FIFO stalls shifting. PE contents hold, because `enableShiftOut` is low and `enableMul` is low.
- FIFO behaviour:
  - `outValid = !empty`; `outData`/`outLast` come from the head entry.
  - A pop happens on `outValid && outReady`.
  - Simultaneous push and pop leaves the count unchanged.
  - No push while full, so there is no full-bypass.
- `mulActive` rising during SHIFT/FLUSH is an integration error. The block continues draining; the bench flags an assertion.
- Reset values: state IDLE, count 0, FIFO empty, `outValid`/`outLast`/`busy`/`done`/`enableShiftOut` 0, `outData` 0 (FIFO storage cleared), `cTopOut` 0.

## Timing
- `start` is sampled at edge E0. SHIFT begins at cycle 1, and `enableShiftOut` is high in cycle 1 unless the FIFO is full.
- The first word is visible on `outData` with `outValid` in cycle 2. Latency from `start` to first valid is 2 cycles.
- With `outReady` held high: ROWS shift cycles, the last word is valid at cycle ROWS+1, and `done` is high at cycle ROWS+2. `busy` covers cycles 1..ROWS+1.
- `outValid` and `outData` are registered. Once `outValid` is high, `outData` holds stable until accepted.
- Reset asserted mid-drain: the next cycle is in reset state. Partially shifted PE contents are lost (PEs reset on the same `reset`). No `done` is generated.
- `start` arriving in the `done` cycle (state IDLE) is accepted.

## Structure
- Package `pe_drain_pkg`: state enum typedef (IDLE, SHIFT, FLUSH) and a `drainWord` struct {last, data}, with the data width taken from the parameters.
- Sub-module `drain_fifo`: synchronous FIFO of `drainWord` (parameter DEPTH). It has pointers, a count, and `full`/`empty` outputs.
- The top level holds the FSM, shiftCount, and `done`/`busy` logic.

## Test plan
- **Basic drain:** ROWS=4, PE model holds 0x0101, 0x0102, 0x0103, 0x0104 top→bottom, `outReady`=1, `start` at cycle 0 → `outData` 0x0104, 0x0103, 0x0102, 0x0101 in cycles 2–5, `outLast` only on 0x0101, `done` in cycle 6, `enableShiftOut` high in cycles 1–4 only.
- **Backpressure:** FIFO_DEPTH=2, `outReady`=0 until cycle 8 → `enableShiftOut` high in cycles 1–2 only, then low. The PE column holds its remaining 2 words; after `outReady` rises, all 4 words arrive in order with none lost or duplicated.
- **Blocked start:** `start` with `mulActive`=1 → stays IDLE, `enableShiftOut` never asserts. `start` in SHIFT is ignored, so exactly 4 words are produced.
- **Mid-drain reset:** reset in cycle 3 of the basic drain → cycle 4 shows IDLE, `outValid`=0, `busy`=0, no `done`. A new `start` then drains cleanly.
- **Ready toggling:** `outReady` toggles every cycle → words in order, each `outData` stable while `outValid && !outReady`, `done` exactly once.
- **ROWS=1 corner:** single shift, the word is marked `outLast`, and `done` is high in cycle 3.

Source files
------------

// File: rtl/pe_drain_pkg.sv
// Shared types for the systolic column result-drain controller.
// Holds the drain FSM states and the FIFO entry layout for the default accumulator geometry.
package pe_drain_pkg;

    localparam int DEF_EXP_OUT  = 5;
    localparam int DEF_FRAC_OUT = 8;

    function automatic int wordWidth(input int expOut, input int fracOut);
        return expOut + fracOut + 1;
    endfunction

    localparam int DEF_WORD_W = wordWidth(DEF_EXP_OUT, DEF_FRAC_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } drainState_e;

    typedef struct packed {
        logic                  last;
        logic [DEF_WORD_W-1:0] data;
    } drainWord;

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO carrying drained accumulator words with their last-row flag.
// Pushes are dropped when full and pops when empty; storage is cleared on reset.
module drain_fifo
    import pe_drain_pkg::*;
#(
    parameter type ENTRY_T = drainWord,
    parameter int  DEPTH   = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  ENTRY_T pushData,
    input  logic   pop,
    output ENTRY_T headData,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ENTRY_T             mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pushEn;
    logic               popEn;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pushEn   = push && !full;
    assign popEn    = pop && !empty;
    assign headData = mem_q[rdPtr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
        if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (pushEn) mem_q[wrPtr_q] <= pushData;
        end
    end

endmodule

// File: rtl/pe_column_drain.sv
// Drains one systolic column: shifts PE accumulators out bottom-first and streams them
// through a FIFO on a valid/ready interface, stalling the shift chain under backpressure.
module pe_column_drain
    import pe_drain_pkg::*;
#(
    parameter int EXP_OUT    = 5,
    parameter int FRAC_OUT   = 8,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mulActive,
    input  logic [EXP_OUT+FRAC_OUT:0]  cChainIn,
    output logic [EXP_OUT+FRAC_OUT:0]  cTopOut,
    output logic                       enableShiftOut,
    output logic [EXP_OUT+FRAC_OUT:0]  outData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       outLast,
    output logic                       busy,
    output logic                       done
);

    localparam int W     = wordWidth(EXP_OUT, FRAC_OUT);
    localparam int CNT_W = $clog2(ROWS + 1);

    // Same layout as drainWord, sized for this instance's accumulator width.
    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } colWord_t;

    drainState_e      state_q, state_d;
    logic [CNT_W-1:0] shiftCount_q, shiftCount_d;
    logic             done_q, done_d;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             popWord;
    colWord_t         pushWord;
    colWord_t         headWord;

    assign enableShiftOut = (state_q == SHIFT) && !fifoFull;
    assign pushWord.last  = (shiftCount_q == CNT_W'(ROWS - 1));
    assign pushWord.data  = cChainIn;
    assign popWord        = !fifoEmpty && outReady;

    drain_fifo #(
        .ENTRY_T (colWord_t),
        .DEPTH   (FIFO_DEPTH)
    ) uFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (enableShiftOut),
        .pushData (pushWord),
        .pop      (popWord),
        .headData (headWord),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // The last word can only reach the FIFO head after the SHIFT->FLUSH edge,
    // so FLUSH is the only state that needs to watch for it leaving.
    always_comb begin
        state_d      = state_q;
        shiftCount_d = shiftCount_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !mulActive) begin
                    state_d      = SHIFT;
                    shiftCount_d = '0;
                end
            end
            SHIFT: begin
                if (enableShiftOut) begin
                    shiftCount_d = shiftCount_q + 1'b1;
                    if (pushWord.last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (popWord && headWord.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shiftCount_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shiftCount_q <= shiftCount_d;
            done_q       <= done_d;
        end
    end

    assign cTopOut  = '0;
    assign outValid = !fifoEmpty;
    assign outData  = headWord.data;
    assign outLast  = headWord.last && !fifoEmpty;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_pe_column_drain.sv
// Self-checking bench: three drain instances (4 rows/depth 4, 4 rows/depth 2, 1 row) fed by
// behavioural PE-column models, checked against expected word order and cycle timing.
module tb_pe_column_drain;

    localparam int W = 14;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checkCount = 0;
    int failCount  = 0;

    logic         startA, mulA, readyA, enA, validA, lastA, busyA, doneA, loadA;
    logic [W-1:0] chainA, topA, dataA;
    logic [W-1:0] peA [4];
    logic [W-1:0] loadValsA [4];

    logic         startB, mulB, readyB, enB, validB, lastB, busyB, doneB, loadB;
    logic [W-1:0] chainB, topB, dataB;
    logic [W-1:0] peB [4];
    logic [W-1:0] loadValsB [4];

    logic         startC, mulC, readyC, enC, validC, lastC, busyC, doneC, loadC;
    logic [W-1:0] chainC, topC, dataC;
    logic [W-1:0] peC [1];
    logic [W-1:0] loadValC;

    pe_column_drain #(.EXP_OUT(5), .FRAC_OUT(8), .ROWS(4), .FIFO_DEPTH(4)) dutA (
        .clock(clock), .reset(reset), .start(startA), .mulActive(mulA), .cChainIn(chainA),
        .cTopOut(topA), .enableShiftOut(enA), .outData(dataA), .outValid(validA),
        .outReady(readyA), .outLast(lastA), .busy(busyA), .done(doneA));

    pe_column_drain #(.EXP_OUT(5), .FRAC_OUT(8), .ROWS(4), .FIFO_DEPTH(2)) dutB (
        .clock(clock), .reset(reset), .start(startB), .mulActive(mulB), .cChainIn(chainB),
        .cTopOut(topB), .enableShiftOut(enB), .outData(dataB), .outValid(validB),
        .outReady(readyB), .outLast(lastB), .busy(busyB), .done(doneB));

    pe_column_drain #(.EXP_OUT(5), .FRAC_OUT(8), .ROWS(1), .FIFO_DEPTH(4)) dutC (
        .clock(clock), .reset(reset), .start(startC), .mulActive(mulC), .cChainIn(chainC),
        .cTopOut(topC), .enableShiftOut(enC), .outData(dataC), .outValid(validC),
        .outReady(readyC), .outLast(lastC), .busy(busyC), .done(doneC));

    // PE column models: index 0 is the top PE, the last index feeds cChainIn.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) peA[i] <= '0;
        end else if (loadA) begin
            for (int i = 0; i < 4; i++) peA[i] <= loadValsA[i];
        end else if (enA) begin
            for (int i = 3; i > 0; i--) peA[i] <= peA[i-1];
            peA[0] <= topA;
        end
    end
    assign chainA = peA[3];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) peB[i] <= '0;
        end else if (loadB) begin
            for (int i = 0; i < 4; i++) peB[i] <= loadValsB[i];
        end else if (enB) begin
            for (int i = 3; i > 0; i--) peB[i] <= peB[i-1];
            peB[0] <= topB;
        end
    end
    assign chainB = peB[3];

    always @(posedge clock) begin
        if (reset)      peC[0] <= '0;
        else if (loadC) peC[0] <= loadValC;
        else if (enC)   peC[0] <= topC;
    end
    assign chainC = peC[0];

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full drain of column A; readyMode 0 = always ready, 1 = toggling, 2 = random.
    task automatic applyStimulus(input logic [W-1:0] words [4], input int readyMode, input bit startAgain);
        logic [W-1:0] expQ [$];
        logic [W-1:0] prevData;
        bit           prevStall;
        int           doneSeen;
        int           lastPopCyc;
        loadValsA = words;
        loadA = 1'b1;
        stepCycle();
        loadA = 1'b0;
        for (int i = 3; i >= 0; i--) expQ.push_back(words[i]);
        mulA   = 1'b0;
        readyA = 1'b1;
        startA = 1'b1;
        stepCycle();
        startA     = 1'b0;
        prevStall  = 1'b0;
        prevData   = '0;
        doneSeen   = 0;
        lastPopCyc = -10;
        for (int cyc = 1; cyc < 80; cyc++) begin
            case (readyMode)
                0:       readyA = 1'b1;
                1:       readyA = cyc[0];
                default: readyA = ($urandom_range(0, 3) != 0);
            endcase
            startA = (startAgain && cyc == 2);
            if (prevStall) checkOutput("A held data", 32'(dataA), 32'(prevData));
            if (doneA) begin
                doneSeen++;
                checkOutput("A done timing", 32'(cyc), 32'(lastPopCyc + 1));
            end
            if (validA) begin
                if (expQ.size() == 0) begin
                    checkOutput("A extra word", 32'(validA), 32'(0));
                end else if (readyA) begin
                    checkOutput("A word", 32'(dataA), 32'(expQ[0]));
                    checkOutput("A last", 32'(lastA), 32'(expQ.size() == 1));
                    void'(expQ.pop_front());
                    if (expQ.size() == 0) lastPopCyc = cyc;
                end
            end
            prevStall = validA && !readyA;
            prevData  = dataA;
            if (expQ.size() == 0 && cyc > lastPopCyc + 2) break;
            stepCycle();
        end
        startA = 1'b0;
        checkOutput("A words left", 32'(expQ.size()), 32'(0));
        checkOutput("A done count", 32'(doneSeen), 32'(1));
        checkOutput("A idle after", 32'(busyA), 32'(0));
    endtask

    initial begin
        logic [W-1:0] wv [4];
        logic [W-1:0] qB [$];
        int           doneCntB;
        int           lastPopB;

        reset  = 1'b1;
        startA = 0; mulA = 0; readyA = 0; loadA = 0;
        startB = 0; mulB = 0; readyB = 0; loadB = 0;
        startC = 0; mulC = 0; readyC = 0; loadC = 0;
        for (int i = 0; i < 4; i++) begin
            loadValsA[i] = '0;
            loadValsB[i] = '0;
        end
        loadValC = '0;
        repeat (3) stepCycle();
        checkOutput("reset valid", 32'(validA), 32'(0));
        checkOutput("reset busy", 32'(busyA), 32'(0));
        checkOutput("reset done", 32'(doneA), 32'(0));
        checkOutput("reset enable", 32'(enA), 32'(0));
        checkOutput("reset data", 32'(dataA), 32'(0));
        checkOutput("reset last", 32'(lastA), 32'(0));
        checkOutput("reset top", 32'(topA), 32'(0));
        reset = 1'b0;
        stepCycle();

        // Basic drain: cycle-exact timing against the documented schedule.
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0101 + i);
        loadValsA = wv;
        loadA  = 1'b1;
        readyA = 1'b1;
        stepCycle();
        loadA  = 1'b0;
        startA = 1'b1;
        stepCycle();
        startA = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checkOutput("basic enable", 32'(enA), 32'(c <= 4));
            checkOutput("basic valid", 32'(validA), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) checkOutput("basic data", 32'(dataA), 32'(wv[5-c]));
            checkOutput("basic last", 32'(lastA), 32'(c == 5));
            checkOutput("basic busy", 32'(busyA), 32'(c <= 5));
            checkOutput("basic done", 32'(doneA), 32'(c == 6));
            stepCycle();
        end

        // Blocked start while the array is multiplying.
        mulA   = 1'b1;
        startA = 1'b1;
        stepCycle();
        startA = 1'b0;
        mulA   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("blocked busy", 32'(busyA), 32'(0));
            checkOutput("blocked enable", 32'(enA), 32'(0));
            checkOutput("blocked valid", 32'(validA), 32'(0));
            stepCycle();
        end

        // A second start during SHIFT must not add words.
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0111 + i);
        applyStimulus(wv, 0, 1'b1);

        // Consumer ready toggling every cycle.
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0121 + i);
        applyStimulus(wv, 1, 1'b0);

        // Reset in cycle 3 of a drain.
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0131 + i);
        loadValsA = wv;
        loadA  = 1'b1;
        readyA = 1'b1;
        stepCycle();
        loadA  = 1'b0;
        startA = 1'b1;
        stepCycle();
        startA = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();
        checkOutput("midreset busy", 32'(busyA), 32'(0));
        checkOutput("midreset valid", 32'(validA), 32'(0));
        checkOutput("midreset enable", 32'(enA), 32'(0));
        checkOutput("midreset done", 32'(doneA), 32'(0));
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput("midreset no done", 32'(doneA), 32'(0));
        end
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0141 + i);
        applyStimulus(wv, 0, 1'b0);

        // Backpressure on the depth-2 instance.
        for (int i = 0; i < 4; i++) wv[i] = 14'(32'h0201 + i);
        loadValsB = wv;
        loadB  = 1'b1;
        readyB = 1'b0;
        stepCycle();
        loadB  = 1'b0;
        startB = 1'b1;
        stepCycle();
        startB = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checkOutput("bp enable", 32'(enB), 32'(c <= 2));
            stepCycle();
        end
        checkOutput("bp head held", 32'(dataB), 32'(wv[3]));
        for (int i = 3; i >= 0; i--) qB.push_back(wv[i]);
        doneCntB = 0;
        lastPopB = -10;
        readyB   = 1'b1;
        for (int c = 8; c < 60; c++) begin
            if (doneB) begin
                doneCntB++;
                checkOutput("bp done timing", 32'(c), 32'(lastPopB + 1));
            end
            if (validB) begin
                if (qB.size() == 0) begin
                    checkOutput("bp extra word", 32'(validB), 32'(0));
                end else begin
                    checkOutput("bp word", 32'(dataB), 32'(qB[0]));
                    checkOutput("bp last", 32'(lastB), 32'(qB.size() == 1));
                    void'(qB.pop_front());
                    if (qB.size() == 0) lastPopB = c;
                end
            end
            if (qB.size() == 0 && c > lastPopB + 2) break;
            stepCycle();
        end
        checkOutput("bp words left", 32'(qB.size()), 32'(0));
        checkOutput("bp done count", 32'(doneCntB), 32'(1));

        // Single-row column.
        loadValC = 14'h0301;
        loadC  = 1'b1;
        readyC = 1'b1;
        stepCycle();
        loadC  = 1'b0;
        startC = 1'b1;
        stepCycle();
        startC = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkOutput("row1 enable", 32'(enC), 32'(c == 1));
            checkOutput("row1 valid", 32'(validC), 32'(c == 2));
            if (c == 2) checkOutput("row1 data", 32'(dataC), 32'(14'h0301));
            checkOutput("row1 last", 32'(lastC), 32'(c == 2));
            checkOutput("row1 busy", 32'(busyC), 32'(c <= 2));
            checkOutput("row1 done", 32'(doneC), 32'(c == 3));
            stepCycle();
        end

        // Randomized drains with random readiness, blocked starts and idle gaps.
        for (int iter = 0; iter < 20; iter++) begin
            for (int i = 0; i < 4; i++) wv[i] = 14'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                mulA   = 1'b1;
                startA = 1'b1;
                stepCycle();
                startA = 1'b0;
                mulA   = 1'b0;
                checkOutput("rand blocked busy", 32'(busyA), 32'(0));
            end
            repeat ($urandom_range(0, 3)) stepCycle();
            applyStimulus(wv, 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
